apb_master_arb: RTL and testbench

Two-requester APB master that shares the APB bus between two local requesters and sequences the SETUP/ACCESS phases toward two APB slaves. Slave select is decoded from the request address; each slave holds a 256-entry, 8-bit memory. The block arbitrates round-robin, performs one transfer at a time, returns read data and a per-requester completion pulse, and optionally aborts transfers whose slave never raises PREADY.

---
 rtl/apb_master_arb.sv | 180 ++++++++++++++++++
 tb/tb_apb_master_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arb.sv
// apb_master_arb
// Two-requester APB master. Arbitrates round-robin between two local
// requesters, runs one SETUP/ACCESS transfer at a time toward two slaves
// (slave picked by the address MSB), returns read data and a per-requester
// DONE pulse.
// Optional feature macro: APB_ARB_TIMEOUT_EN -- aborts an ACCESS phase that
// sees no PREADY for TIMEOUT cycles and flags it on ERR_o.
module apb_master_arb #(
    parameter int data_size    = 7,
    parameter int address_size = 8
`ifdef APB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = 15
`endif
) (
    input  logic                  PCLK,
    input  logic                  PRESET_n,
    input  logic                  REQ0_i,
    input  logic                  REQ1_i,
    input  logic                  WR0_i,
    input  logic                  WR1_i,
    input  logic [address_size:0] ADDR0_i,
    input  logic [address_size:0] ADDR1_i,
    input  logic [data_size:0]    WDATA0_i,
    input  logic [data_size:0]    WDATA1_i,
    output logic                  DONE0_o,
    output logic                  DONE1_o,
    output logic [data_size:0]    RDATA_o,
    output logic                  ERR_o,
    output logic                  BUSY_o,
    output logic                  PSEL1_o,
    output logic                  PSEL2_o,
    output logic                  PENABLE_o,
    output logic                  PWRITE_o,
    output logic [address_size:0] PADDR_o,
    output logic [data_size:0]    PWDATA_o,
    input  logic [data_size:0]    PRDATA1_i,
    input  logic [data_size:0]    PRDATA2_i,
    input  logic                  PREADY_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  wr_q, wr_d;
    logic [address_size:0] addr_q, addr_d;
    logic [data_size:0]    wdata_q, wdata_d;
    logic [data_size:0]    rdata_q, rdata_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;
    logic                  err_d;
    logic                  win;
    logic                  busy;
    logic [data_size:0]    prdata_sel;

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [3:0] TO_CNT = 4'(TIMEOUT);
    logic [3:0] cnt_q, cnt_d;
    logic       err_q;
`endif

    // Tie goes to the requester not granted last; a lone request always wins.
    assign win = (REQ0_i && REQ1_i) ? ~last_q : (REQ1_i && !REQ0_i);

    assign prdata_sel = addr_q[address_size] ? PRDATA2_i : PRDATA1_i;

    // Next-state logic. The DONE cycle doubles as the mandatory IDLE gap,
    // so arbitration waits until it has passed.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err_d   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if ((REQ0_i || REQ1_i) && !(done0_q || done1_q)) begin
                    state_d = SETUP;
                    owner_d = win;
                    last_d  = win;
                    wr_d    = win ? WR1_i    : WR0_i;
                    addr_d  = win ? ADDR1_i  : ADDR0_i;
                    wdata_d = win ? WDATA1_i : WDATA0_i;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                cnt_d   = 4'd0;
`endif
            end
            ACCESS: begin
                if (PREADY_i) begin
                    state_d = IDLE;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    if (!wr_q) rdata_d = prdata_sel;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == TO_CNT) begin
                        state_d = IDLE;
                        done0_d = !owner_q;
                        done1_d = owner_q;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command registers; reset discards any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    // Timeout counter and error pulse.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign ERR_o = err_q;
`else
    assign ERR_o = err_d;
`endif

    assign busy      = (state_q != IDLE);
    assign BUSY_o    = busy;
    assign PSEL1_o   = busy && !addr_q[address_size];
    assign PSEL2_o   = busy &&  addr_q[address_size];
    assign PENABLE_o = (state_q == ACCESS);
    assign PWRITE_o  = wr_q;
    assign PADDR_o   = addr_q;
    assign PWDATA_o  = wdata_q;
    assign RDATA_o   = rdata_q;
    assign DONE0_o   = done0_q;
    assign DONE1_o   = done1_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: two APB slave models with random wait states,
// a transaction-level reference model, directed scenarios and a random
// two-requester phase.
module tb_apb_master_arb;

    logic       PCLK = 1'b0;
    logic       PRESET_n;
    logic       REQ0_i = 1'b0, REQ1_i = 1'b0, WR0_i = 1'b0, WR1_i = 1'b0;
    logic [8:0] ADDR0_i = '0, ADDR1_i = '0;
    logic [7:0] WDATA0_i = '0, WDATA1_i = '0;
    logic       DONE0_o, DONE1_o, ERR_o, BUSY_o, PSEL1_o, PSEL2_o, PENABLE_o, PWRITE_o;
    logic [7:0] RDATA_o, PWDATA_o, PRDATA1_i, PRDATA2_i;
    logic [8:0] PADDR_o;
    logic       PREADY_i;

    apb_master_arb dut (
        .PCLK(PCLK), .PRESET_n(PRESET_n),
        .REQ0_i(REQ0_i), .REQ1_i(REQ1_i), .WR0_i(WR0_i), .WR1_i(WR1_i),
        .ADDR0_i(ADDR0_i), .ADDR1_i(ADDR1_i), .WDATA0_i(WDATA0_i), .WDATA1_i(WDATA1_i),
        .DONE0_o(DONE0_o), .DONE1_o(DONE1_o), .RDATA_o(RDATA_o), .ERR_o(ERR_o),
        .BUSY_o(BUSY_o), .PSEL1_o(PSEL1_o), .PSEL2_o(PSEL2_o), .PENABLE_o(PENABLE_o),
        .PWRITE_o(PWRITE_o), .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o),
        .PRDATA1_i(PRDATA1_i), .PRDATA2_i(PRDATA2_i), .PREADY_i(PREADY_i)
    );

    always #5 PCLK = ~PCLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- slave models ----------------
    logic [7:0] s1_mem [256];
    logic [7:0] s2_mem [256];
    logic       pr1, pr2;
    int         scnt, stall;
    int         max_stall = 0;
    bit         hold_pready = 1'b0;

    assign PREADY_i  = pr1 | pr2;
    assign PRDATA1_i = s1_mem[PADDR_o[7:0]];
    assign PRDATA2_i = s2_mem[PADDR_o[7:0]];

    // Slaves: PREADY after 'stall' extra cycles, write on the completing edge.
    always @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            pr1 <= 1'b0; pr2 <= 1'b0; scnt <= 0; stall <= 0;
            for (int i = 0; i < 256; i++) begin s1_mem[i] <= 8'h00; s2_mem[i] <= 8'h00; end
        end else if ((PSEL1_o || PSEL2_o) && PENABLE_o && !PREADY_i) begin
            if (!hold_pready && scnt >= stall) begin
                if (PSEL1_o) pr1 <= 1'b1; else pr2 <= 1'b1;
                scnt <= 0;
            end else scnt <= scnt + 1;
        end else begin
            pr1 <= 1'b0; pr2 <= 1'b0; scnt <= 0;
            if (PSEL1_o && PENABLE_o && pr1 && PWRITE_o) s1_mem[PADDR_o[7:0]] <= PWDATA_o;
            if (PSEL2_o && PENABLE_o && pr2 && PWRITE_o) s2_mem[PADDR_o[7:0]] <= PWDATA_o;
            if (PREADY_i) stall <= int'($urandom_range(0, max_stall));
        end
    end

    // ---------------- reference model ----------------
`ifdef APB_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 15;
`endif
    logic [7:0] m_mem [512];
    bit         m_busy, m_acc, m_cool, m_last, m_owner, m_wr, m_err;
    logic [8:0] m_addr;
    logic [7:0] m_wdata, m_rdata;
    logic [1:0] m_done;
    int         m_wait;

    function automatic bit pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) return (last == 1'b0) ? 1'b1 : 1'b0;
        else if (r1) return 1'b1;
        else return 1'b0;
    endfunction

    // One transaction record: granted, one SETUP cycle, ACCESS until ready.
    always @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            m_busy <= 0; m_acc <= 0; m_cool <= 0; m_last <= 1; m_owner <= 0;
            m_wr <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
            m_done <= 2'b00; m_err <= 0; m_wait <= 0;
            for (int i = 0; i < 512; i++) m_mem[i] <= 8'h00;
        end else begin
            m_done <= 2'b00; m_err <= 0; m_cool <= 0;
            if (!m_busy) begin
                if (!m_cool && (REQ0_i || REQ1_i)) begin
                    m_busy  <= 1; m_acc <= 0;
                    m_owner <= pick(REQ0_i, REQ1_i, m_last);
                    m_last  <= pick(REQ0_i, REQ1_i, m_last);
                    m_wr    <= pick(REQ0_i, REQ1_i, m_last) ? WR1_i    : WR0_i;
                    m_addr  <= pick(REQ0_i, REQ1_i, m_last) ? ADDR1_i  : ADDR0_i;
                    m_wdata <= pick(REQ0_i, REQ1_i, m_last) ? WDATA1_i : WDATA0_i;
                end
            end else if (!m_acc) begin
                m_acc <= 1; m_wait <= 0;
            end else if (PREADY_i) begin
                m_busy <= 0; m_cool <= 1; m_done[m_owner] <= 1'b1;
                if (m_wr) m_mem[m_addr] <= m_wdata;
                else m_rdata <= m_mem[m_addr];
            end else begin
                m_wait <= m_wait + 1;
`ifdef APB_ARB_TIMEOUT_EN
                if (m_wait + 1 == TIMEOUT) begin
                    m_busy <= 0; m_cool <= 1; m_done[m_owner] <= 1'b1; m_err <= 1;
                end
`endif
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge PCLK) begin
        chk("PSEL1", PSEL1_o, m_busy && !m_addr[8]);
        chk("PSEL2", PSEL2_o, m_busy && m_addr[8]);
        chk("PENABLE", PENABLE_o, m_busy && m_acc);
        chk("BUSY", BUSY_o, m_busy);
        chk("PWRITE", PWRITE_o, m_wr);
        chk("PADDR", PADDR_o, m_addr);
        chk("PWDATA", PWDATA_o, m_wdata);
        chk("RDATA", RDATA_o, m_rdata);
        chk("DONE0", DONE0_o, m_done[0]);
        chk("DONE1", DONE1_o, m_done[1]);
        chk("ERR", ERR_o, m_err);
        chk("pen_nosel", PENABLE_o && !(PSEL1_o || PSEL2_o), 1'b0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic drive(input bit id, input bit r, input bit w, input logic [8:0] a, input logic [7:0] d);
        if (id) begin REQ1_i = r; WR1_i = w; ADDR1_i = a; WDATA1_i = d; end
        else    begin REQ0_i = r; WR0_i = w; ADDR0_i = a; WDATA0_i = d; end
    endtask

    task automatic wait_done(input bit id, output int n, output logic [1:0] sm);
        bit got = 1'b0;
        n = 0; sm = 2'b00;
        while (!got && n < 100) begin
            tick(); n++;
            sm |= {PSEL2_o, PSEL1_o};
            got = id ? DONE1_o : DONE0_o;
        end
        if (!got) chk("done_wait", 0, 1);
    endtask

    task automatic xfer(input bit id, input bit w, input logic [8:0] a, input logic [7:0] d,
                        output int lat, output logic [1:0] sm);
        tick();
        drive(id, 1'b1, w, a, d);
        wait_done(id, lat, sm);
        drive(id, 1'b0, w, a, d);
    endtask

    function automatic logic [8:0] rnd_addr();
        return {1'($urandom_range(0, 1)), 4'h4, 4'($urandom_range(0, 15))};
    endfunction

    task automatic requester(input bit id, input int n);
        bit         got;
        logic [8:0] a;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            a = rnd_addr();
            drive(id, 1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom));
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                tick();
                if (id ? DONE1_o : DONE0_o) got = 1'b1;
                else if ($urandom_range(0, 3) == 0)
                    drive(id, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom));
            end
            if (!got) chk("req_done", 0, 1);
            drive(id, 1'b0, 1'b0, a, 8'h00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int         lat, n;
        logic [1:0] sm;
        int         ord [4];
        int         tdn [4];
        bit         sawd;

        PRESET_n = 1'b1;
        #1 PRESET_n = 1'b0;
        #2;
        chk("rst_busy", BUSY_o, 0);
        chk("rst_psel", {PSEL1_o, PSEL2_o, PENABLE_o, PWRITE_o}, 0);
        chk("rst_bus", {PADDR_o, PWDATA_o, RDATA_o}, 0);
        chk("rst_pulse", {DONE0_o, DONE1_o, ERR_o}, 0);
        repeat (2) @(posedge PCLK);
        #2 PRESET_n = 1'b1;

        // requester 0, slave 1: write then read back
        xfer(0, 1, 9'h045, 8'hA5, lat, sm);
        chk("wr0_lat", lat, 4); chk("wr0_sel", sm, 2'b01);
        xfer(0, 0, 9'h045, 8'h00, lat, sm);
        chk("rd0_lat", lat, 4); chk("rd0_sel", sm, 2'b01); chk("rd0_data", RDATA_o, 8'hA5);

        // requester 1, slave 2 decode
        xfer(1, 1, 9'h17F, 8'h3C, lat, sm);
        chk("wr1_lat", lat, 4); chk("wr1_sel", sm, 2'b10);
        xfer(1, 0, 9'h17F, 8'h00, lat, sm);
        chk("rd1_sel", sm, 2'b10); chk("rd1_data", RDATA_o, 8'h3C);
        xfer(1, 0, 9'h07F, 8'h00, lat, sm);
        chk("rd1_s1_sel", sm, 2'b01); chk("rd1_s1_data", RDATA_o, 8'h00);

        // request fields changed during SETUP are ignored
        tick();
        drive(0, 1, 1, 9'h0AA, 8'h11);
        tick();
        drive(0, 1, 0, 9'h155, 8'hEE);
        #1;
        chk("hold_paddr", PADDR_o, 9'h0AA);
        chk("hold_pwdata", PWDATA_o, 8'h11);
        chk("hold_pwrite", PWRITE_o, 1);
        wait_done(0, n, sm);
        drive(0, 0, 0, 9'h000, 8'h00);
        chk("hold_mem", s1_mem[8'hAA], 8'h11);

        // round-robin from reset with both requests held
        tick(); PRESET_n = 1'b0;
        tick(); tick(); PRESET_n = 1'b1;
        REQ0_i = 1; WR0_i = 0; ADDR0_i = 9'h045;
        REQ1_i = 1; WR1_i = 0; ADDR1_i = 9'h17F;
        n = 0;
        for (int c = 1; c <= 60 && n < 4; c++) begin
            tick();
            if (DONE0_o) begin ord[n] = 0; tdn[n] = c; n++; end
            else if (DONE1_o) begin ord[n] = 1; tdn[n] = c; n++; end
        end
        REQ0_i = 0; REQ1_i = 0;
        chk("rr_count", n, 4);
        if (n == 4) begin
            chk("rr_first", tdn[0], 4);
            for (int i = 0; i < 4; i++) chk("rr_order", ord[i], i % 2);
            for (int i = 1; i < 4; i++) chk("rr_gap", tdn[i] - tdn[i-1], 5);
        end

        // reset in the middle of ACCESS
        hold_pready = 1'b1;
        tick();
        drive(0, 1, 0, 9'h033, 8'h00);
        tick(); tick(); tick();
        chk("rst_mid_pen", PENABLE_o, 1);
        #1 PRESET_n = 1'b0;
        #1;
        chk("rst_mid_sel", {PSEL1_o, PSEL2_o, PENABLE_o, BUSY_o}, 0);
        chk("rst_mid_bus", {PADDR_o, PWDATA_o, RDATA_o}, 0);
        chk("rst_mid_done", {DONE0_o, DONE1_o, ERR_o}, 0);
        drive(0, 0, 0, 9'h000, 8'h00);
        hold_pready = 1'b0;
        tick(); tick(); PRESET_n = 1'b1;
        sawd = 1'b0;
        repeat (6) begin tick(); sawd |= DONE0_o | DONE1_o; end
        chk("rst_no_done", sawd, 0);
        xfer(0, 1, 9'h033, 8'h5A, lat, sm);
        chk("post_rst_lat", lat, 4);
        xfer(0, 0, 9'h033, 8'h00, lat, sm);
        chk("post_rst_data", RDATA_o, 8'h5A);

`ifdef APB_ARB_TIMEOUT_EN
        // slave never answers: abort after TIMEOUT ACCESS cycles
        hold_pready = 1'b1;
        xfer(0, 0, 9'h010, 8'h00, lat, sm);
        chk("to_lat", lat, 2 + TIMEOUT);
        chk("to_err", ERR_o, 1);
        chk("to_rdata", RDATA_o, 8'h5A);
        hold_pready = 1'b0;
        tick();
        chk("to_busy", BUSY_o, 0);
        chk("to_err_pulse", ERR_o, 0);
`endif

        // random two-requester traffic with slave wait states
        max_stall = 3;
        fork
            requester(0, 30);
            requester(1, 30);
        join
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
